fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch controller feeding the execution stage (pc_i/inst_v_i/inst_i); consumes its redirect (pc_v_x/pc_x).
//  Issues in-order word requests to instruction memory via req/gnt + rvalid handshake.
//  Buffers returned words with their PC; kills wrong-path fetches on branch redirect.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
//  BUF_DEPTH  2              instruction buffer entries; also max (outstanding + buffered), 1..3
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high
//  imem_req_o    out  1   fetch request valid
//  imem_addr_o   out  32  fetch word address (bits[1:0]=0)
//  imem_gnt_i    in   1   request accepted this cycle (req&gnt = handshake)
//  imem_rvalid_i in   1   read data valid; in request order, >=1 cycle after gnt
//  imem_rdata_i  in   32  instruction word
//  redir_v_i     in   1   branch taken (execution pc_v_x)
//  redir_pc_i    in   32  branch target (execution pc_x)
//  inst_ready_i  in   1   execution accepts instruction (tie 1 when no stall)
//  inst_v_o      out  1   instruction valid to execution (inst_v_i)
//  inst_o        out  32  instruction word (inst_i)
//  pc_o          out  32  PC of inst_o (pc_i)
// BEHAVIOUR
//  Reset values: imem_req_o=0, inst_v_o=0, fetch_pc=RESET_PC, outstanding=0, discard=0, buffer empty, state=BOOT.
//  FSM: BOOT -> FETCH (unconditional, 1 cycle; imem_req_o=0 in BOOT).
//   FETCH: imem_req_o = (outstanding + occupancy < BUF_DEPTH); imem_addr_o = fetch_pc.
//   FETCH + redir_v_i: fetch_pc<=redir_pc_i; flush buffer; discard<=in-flight count incl. gnt this cycle;
//     -> FLUSH if that count>0, else stay FETCH.
//   FLUSH: imem_req_o=0; each rvalid decrements discard and outstanding, data dropped; discard reaching 0 -> FETCH.
//   FLUSH + redir_v_i: fetch_pc<=redir_pc_i, stay FLUSH (discard unchanged).
//  Handshake: req&gnt -> fetch_pc+=4 (mod 2^32 wrap), outstanding++. Addr held stable while req&!gnt,
//   except redirect cycle: req may retarget/drop (memory tolerates).
//  Gnt in redirect cycle belongs to old stream: counted into discard; fetch_pc takes redir_pc_i, not +4.
//  Response (rvalid, discard==0): push {rdata, pc} to buffer; pc per entry = issue addr (held in small FIFO).
//  rvalid with outstanding==0: ignored (defensive, e.g. after reset).
//  rvalid in redirect cycle: treated as stale, dropped, decrements outstanding.
//  Credit rule guarantees push never hits full buffer; assert in sim.
//  Latency: rvalid at cycle t -> inst_v_o at t+1 (registered buffer, no bypass).
//  inst_v_o = buffer non-empty & !redir_v_i & state!=BOOT; pop on inst_v_o & inst_ready_i.
//  redir_v_i suppresses inst_v_o same cycle (kills instruction after branch).
//  Push and pop same cycle: occupancy unchanged, FIFO order kept.
//  Counters: outstanding/occupancy $clog2(BUF_DEPTH+1) bits; never exceed BUF_DEPTH.
//  Reset mid-operation (any state): all state to reset values next edge; outstanding lost.
// TESTING
//  1 Reset release, gnt=1, rvalid 1 cycle after gnt, rdata=32'h00000013 -> addr 0x0,0x4,0x8..; first inst_v_o pc_o=0x0 at rvalid+1.
//  2 inst_ready_i=0 for 6 cycles -> imem_req_o drops once outstanding+occupancy=2; release: pc_o 0x0,0x4,0x8 in order, none lost/duplicated.
//  3 Two outstanding, redir_v_i=1 redir_pc_i=0x100 -> inst_v_o=0 that cycle; next 2 rvalid dropped; next addr 0x100; first inst_v_o pc_o=0x100.
//  4 redir_v_i, gnt, rvalid all same cycle -> rvalid dropped, granted req discarded; fetch resumes at target, never target+4.
//  5 gnt delayed 3 cycles -> imem_addr_o stable 0x8 while req high; fetch_pc=0xFFFF_FFFC wraps to 0x0.
//  6 reset in FLUSH with 1 outstanding -> req=0, inst_v_o=0 next cycle; late rvalid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: issues in-order word requests to instruction memory,
// buffers returned words with their PC, and kills wrong-path fetches on a branch redirect.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redir_v_i,
  input  logic [31:0] redir_pc_i,
  input  logic        inst_ready_i,
  output logic        inst_v_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam int              CW    = $clog2(BUF_DEPTH + 1);
  localparam int              PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0]     DEPTH = (CW+1)'(BUF_DEPTH);
  localparam logic [PW-1:0]   LAST  = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] discard, discard_nxt;
  logic [CW-1:0] occupancy, occupancy_nxt;
  logic [CW-1:0] in_flight;

  logic [31:0]   pcq [BUF_DEPTH];
  logic [PW-1:0] pcq_rd, pcq_wr;
  logic [31:0]   buf_inst [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [PW-1:0] buf_rd, buf_wr;

  logic handshake, rsp, redirect, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Responses with nothing outstanding are stray and ignored entirely.
  assign handshake   = imem_req_o & imem_gnt_i;
  assign rsp         = imem_rvalid_i & (outstanding != '0);
  assign redirect    = redir_v_i & (state != BOOT);
  assign push        = rsp & (state == FETCH) & ~redir_v_i;
  assign pop         = inst_v_o & inst_ready_i;
  assign in_flight   = outstanding + CW'(handshake) - CW'(rsp);

  assign imem_req_o  = (state == FETCH) && (({1'b0, outstanding} + {1'b0, occupancy}) < DEPTH);
  assign imem_addr_o = fetch_pc;
  assign inst_v_o    = (occupancy != '0) & ~redir_v_i & (state != BOOT);
  assign inst_o      = buf_inst[buf_rd];
  assign pc_o        = buf_pc[buf_rd];

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    discard_nxt     = discard;
    outstanding_nxt = in_flight;
    occupancy_nxt   = redirect ? '0 : occupancy + CW'(push) - CW'(pop);
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        // A grant in the redirect cycle belongs to the old stream and is discarded later.
        if (redirect) begin
          fetch_pc_nxt = redir_pc_i;
          discard_nxt  = in_flight;
          state_nxt    = (in_flight != '0) ? FLUSH : FETCH;
        end else if (handshake) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end
      FLUSH: begin
        if (redirect) fetch_pc_nxt = redir_pc_i;
        if (rsp) begin
          discard_nxt = discard - 1'b1;
          if (discard == CW'(1)) state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      occupancy   <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
      buf_rd      <= '0;
      buf_wr      <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      occupancy   <= occupancy_nxt;
      if (handshake) pcq_wr <= next_ptr(pcq_wr);
      if (rsp)       pcq_rd <= next_ptr(pcq_rd);
      if (redirect) begin
        buf_rd <= buf_wr;
      end else begin
        if (push) buf_wr <= next_ptr(buf_wr);
        if (pop)  buf_rd <= next_ptr(buf_rd);
      end
    end
  end

  // Issue-address FIFO and instruction buffer storage carry no reset.
  always_ff @(posedge clk) begin
    if (handshake) pcq[pcq_wr] <= fetch_pc;
    if (push && !redirect) begin
      buf_inst[buf_wr] <= imem_rdata_i;
      buf_pc[buf_wr]   <= pcq[pcq_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && occupancy == CW'(BUF_DEPTH)));
      assert (outstanding <= CW'(BUF_DEPTH));
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: plays instruction memory and execution stage, checking the
// delivered instruction stream and fetch addresses against a program-order model.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redir_v_i;
  logic [31:0] redir_pc_i;
  logic        inst_ready_i;
  logic        inst_v_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  fetch_sequencer #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redir_v_i(redir_v_i), .redir_pc_i(redir_pc_i),
    .inst_ready_i(inst_ready_i), .inst_v_o(inst_v_o), .inst_o(inst_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  mem_req_t pending[$];

  int checks = 0, errors = 0, cyc = 0;
  int gnt_pct, rv_pct, ready_pct, redir_pct, lat_min, lat_max;
  bit const_data;
  int force_mode;
  logic [31:0] force_pc;
  bit force_hit;
  int gnt_hold;
  logic [31:0] hold_addr;
  logic [31:0] exp_fetch, exp_pc, last_grant_addr, prev_addr;
  bit prev_req, prev_gnt, prev_redir, after_reset, wrap_seen;
  int deliveries, first_rv, first_del, d0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return const_data ? 32'h0000_0013 : (a ^ 32'hC0DE_0003);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, check, then advance the model.
  task automatic applyStimulus();
    bit fire, grant, deliver;
    @(negedge clk);
    cyc++;
    imem_gnt_i = ($urandom % 100) < gnt_pct;
    if (gnt_hold > 0 && imem_req_o && imem_addr_o == hold_addr) begin
      imem_gnt_i = 1'b0;
      gnt_hold--;
    end
    if (pending.size() > 0 && pending[0].due <= cyc && ($urandom % 100) < rv_pct) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pending[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    inst_ready_i = ($urandom % 100) < ready_pct;
    redir_v_i    = ($urandom % 100) < redir_pct;
    redir_pc_i   = ((($urandom % 2) != 0) ? 32'hFFFF_FF80 : 32'h0000_0000) + (($urandom % 32) << 2);
    fire = 1'b0;
    case (force_mode)
      1: fire = (pending.size() == 2) && !imem_rvalid_i;
      2: fire = imem_req_o && imem_gnt_i && imem_rvalid_i;
      3: if (pending.size() == 1 && !imem_rvalid_i) begin fire = 1'b1; imem_gnt_i = 1'b0; end
      4: fire = 1'b1;
      default: fire = 1'b0;
    endcase
    if (force_mode != 0) redir_v_i = 1'b0;
    if (fire) begin
      redir_v_i  = 1'b1;
      redir_pc_i = force_pc;
      force_mode = 0;
      force_hit  = 1'b1;
    end
    #1;
    if (after_reset) begin
      checkOutput("boot_then_fetch", imem_req_o, 1);
      after_reset = 1'b0;
    end
    grant   = imem_req_o && imem_gnt_i;
    deliver = inst_v_o && inst_ready_i;
    if (redir_v_i) checkOutput("kill_on_redir", inst_v_o, 0);
    if (imem_req_o) begin
      checkOutput("addr_align", imem_addr_o[1:0], 0);
      checkOutput("credit", pending.size() < BUF_DEPTH, 1);
    end
    if (prev_req && !prev_gnt && !prev_redir && imem_req_o) checkOutput("addr_hold", imem_addr_o, prev_addr);
    if (grant && !redir_v_i) begin
      checkOutput("fetch_addr", imem_addr_o, exp_fetch);
      if (last_grant_addr == 32'hFFFF_FFFC && imem_addr_o == 32'h0) wrap_seen = 1'b1;
      last_grant_addr = imem_addr_o;
    end
    if (deliver) begin
      checkOutput("pc_o", pc_o, exp_pc);
      checkOutput("inst_o", inst_o, mem_word(exp_pc));
      if (first_del < 0) first_del = cyc;
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end
    if (imem_rvalid_i) begin
      if (first_rv < 0) first_rv = cyc;
      void'(pending.pop_front());
    end
    if (grant) pending.push_back('{addr: imem_addr_o, due: cyc + $urandom_range(lat_min, lat_max)});
    if (redir_v_i) begin
      exp_fetch = redir_pc_i;
      exp_pc    = redir_pc_i;
    end else if (grant) begin
      exp_fetch = exp_fetch + 32'd4;
    end
    prev_req   = imem_req_o;
    prev_gnt   = imem_gnt_i;
    prev_redir = redir_v_i;
    prev_addr  = imem_addr_o;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Holds reset for one cycle; late_rv drives a stray response through reset and the boot cycle.
  task automatic doReset(input bit late_rv);
    @(negedge clk);
    reset         = 1'b1;
    imem_gnt_i    = 1'b0;
    redir_v_i     = 1'b0;
    inst_ready_i  = 1'b1;
    imem_rvalid_i = late_rv;
    imem_rdata_i  = $urandom;
    @(negedge clk);
    #1;
    checkOutput("reset_req", imem_req_o, 0);
    checkOutput("reset_inst_v", inst_v_o, 0);
    reset = 1'b0;
    pending.delete();
    exp_fetch       = RESET_PC;
    exp_pc          = RESET_PC;
    last_grant_addr = 32'h1;
    prev_req        = 1'b0;
    first_rv        = -1;
    first_del       = -1;
    after_reset     = 1'b1;
  endtask

  initial begin
    reset = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redir_v_i = 1'b0; redir_pc_i = '0; inst_ready_i = 1'b1;
    force_mode = 0; force_hit = 1'b0; gnt_hold = 0; hold_addr = '0; force_pc = '0;
    deliveries = 0; wrap_seen = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0; prev_addr = '0;
    gnt_pct = 100; rv_pct = 100; ready_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
    const_data = 1'b1;

    // Straight-line fetch, constant data, one-cycle memory latency
    doReset(1'b0);
    runCycles(12);
    checkOutput("t1_latency", first_del - first_rv, 1);
    checkOutput("t1_progress", deliveries > 0, 1);

    // Execution stall fills the credit window
    ready_pct = 0;
    runCycles(6);
    checkOutput("t2_req_drop", imem_req_o, 0);
    ready_pct = 100;
    d0 = deliveries;
    runCycles(10);
    checkOutput("t2_progress", deliveries > d0, 1);

    // Redirect with two fetches in flight
    doReset(1'b0);
    const_data = 1'b0;
    lat_min = 3; lat_max = 3;
    force_hit = 1'b0; force_pc = 32'h0000_0100; force_mode = 1;
    runCycles(30);
    checkOutput("t3_redir_hit", force_hit, 1);

    // Redirect coinciding with grant and response
    lat_min = 1; lat_max = 1;
    force_hit = 1'b0; force_pc = 32'h0000_0240; force_mode = 2;
    runCycles(30);
    checkOutput("t4_redir_hit", force_hit, 1);

    // Delayed grant at 0x8, then a redirect that wraps the address space
    doReset(1'b0);
    lat_min = 1; lat_max = 2;
    hold_addr = 32'h0000_0008; gnt_hold = 3;
    runCycles(20);
    checkOutput("t5_hold_done", gnt_hold, 0);
    force_hit = 1'b0; force_pc = 32'hFFFF_FFF8; force_mode = 4;
    runCycles(20);
    checkOutput("t5_redir_hit", force_hit, 1);
    checkOutput("t5_wrap", wrap_seen, 1);

    // Reset while flushing with one fetch outstanding
    doReset(1'b0);
    lat_min = 4; lat_max = 4;
    force_hit = 1'b0; force_pc = 32'h0000_0400; force_mode = 3;
    for (int i = 0; i < 40; i++) if (!force_hit) applyStimulus();
    checkOutput("t6_redir_hit", force_hit, 1);
    doReset(1'b1);
    d0 = deliveries;
    runCycles(20);
    checkOutput("t6_restart", deliveries > d0, 1);

    // Randomised traffic with frequent redirects
    doReset(1'b0);
    gnt_pct = 60; rv_pct = 70; ready_pct = 70; redir_pct = 8; lat_min = 1; lat_max = 4;
    d0 = deliveries;
    runCycles(3000);
    checkOutput("soak_progress", deliveries > d0 + 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
